// File: rtl/dmux8way16_stream.sv
// -----------------------------------------------------------------------------
// dmux8way16_stream
//
// Streaming 1-to-8 demultiplexer for 16-bit words. Each of the eight
// channels holds a single word in a skid-free holding register with a
// full flag. A word is accepted when in_valid && in_ready. A channel
// drains when it is full and its consumer raises out_ready. Because
// in_ready looks at the addressed channel's out_ready, a channel that is
// drained and refilled in the same cycle sustains one word per cycle.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_data[15:0] word to route
//   in_sel[2:0]  destination channel, 0=a .. 7=h
//   in_valid     in_data/in_sel valid this cycle
//   in_ready     addressed channel can take a word this cycle
//   out_a..out_h held word of channels 0..7 (registered)
//   out_valid[7:0] channel i holds a word (registered)
//   out_ready[7:0] consumer i takes its word this cycle
//   word_count[15:0] accepted words since reset, wraps at 2^16
// -----------------------------------------------------------------------------

// One channel: holding register plus full flag.
//   ld    : write d into the register and mark full (wins over drain)
//   drain : consumer takes the word; register keeps its old contents
module dmux8way16_chan (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld,
    input  logic        drain,
    input  logic [15:0] d,
    output logic        full,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            q    <= 16'h0000;
        end else if (ld) begin
            // Covers the drain+refill case too: the new word replaces the
            // one being taken and the channel stays full.
            q    <= d;
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

module dmux8way16_stream (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic [2:0]  in_sel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic [15:0] out_c,
    output logic [15:0] out_d,
    output logic [15:0] out_e,
    output logic [15:0] out_f,
    output logic [15:0] out_g,
    output logic [15:0] out_h,
    output logic [7:0]  out_valid,
    input  logic [7:0]  out_ready,
    output logic [15:0] word_count
);

    localparam int NUM_CH = 8;
    localparam int DW     = 16;

    logic [NUM_CH-1:0]         full;
    logic [NUM_CH-1:0][DW-1:0] hold;
    logic [NUM_CH-1:0]         ld;
    logic [NUM_CH-1:0]         drain;
    logic                      accept;

    // A full channel can still take a word if it is being drained this
    // cycle. During reset every full flag is clear, so in_ready reads 1.
    assign in_ready = !full[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;

    genvar ch;
    generate
        for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
            // out_ready of an empty channel is masked here.
            assign ld[ch]    = accept && (in_sel == 3'(ch));
            assign drain[ch] = full[ch] && out_ready[ch];

            dmux8way16_chan u_chan (
                .clk   (clk),
                .reset (reset),
                .ld    (ld[ch]),
                .drain (drain[ch]),
                .d     (in_data),
                .full  (full[ch]),
                .q     (hold[ch])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            word_count <= 16'h0000;
        else if (accept)
            word_count <= word_count + 16'h0001;
    end

    // Outputs come straight from registers; no input reaches them
    // combinationally.
    assign out_valid = full;
    assign out_a     = hold[0];
    assign out_b     = hold[1];
    assign out_c     = hold[2];
    assign out_d     = hold[3];
    assign out_e     = hold[4];
    assign out_f     = hold[5];
    assign out_g     = hold[6];
    assign out_h     = hold[7];

endmodule

// File: tb/tb_dmux8way16_stream.sv
module tb_dmux8way16_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [15:0] word_count;

    logic [15:0] outs [8];
    assign outs[0] = out_a;
    assign outs[1] = out_b;
    assign outs[2] = out_c;
    assign outs[3] = out_d;
    assign outs[4] = out_e;
    assign outs[5] = out_f;
    assign outs[6] = out_g;
    assign outs[7] = out_h;

    dmux8way16_stream dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_c      (out_c),
        .out_d      (out_d),
        .out_e      (out_e),
        .out_f      (out_f),
        .out_g      (out_g),
        .out_h      (out_h),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Behavioural model: eight slots, each either empty or holding a word,
    // plus a word counter.
    logic [15:0] mbuf  [8];
    bit          mfull [8];
    logic [15:0] mcount;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            mbuf[i]  = 16'h0000;
            mfull[i] = 1'b0;
        end
        mcount = 16'h0000;
    endtask

    // Per-cycle compare at the falling edge, then advance the model by the
    // transfer that the coming rising edge will perform.
    initial begin : compare_proc
        bit          acc;
        logic [7:0]  mvalid;
        forever begin
            @(negedge clk);
            if (reset) begin
                model_clear();
                check("rst_valid", {24'h0, out_valid}, 32'h0);
                check("rst_ready", {31'h0, in_ready}, 32'h1);
                check("rst_count", {16'h0, word_count}, 32'h0);
                for (int i = 0; i < 8; i++)
                    check("rst_out", {16'h0, outs[i]}, 32'h0);
            end else begin
                mvalid = '0;
                for (int i = 0; i < 8; i++) begin
                    mvalid[i] = mfull[i];
                    check($sformatf("out%0d", i), {16'h0, outs[i]}, {16'h0, mbuf[i]});
                end
                check("out_valid", {24'h0, out_valid}, {24'h0, mvalid});
                check("word_count", {16'h0, word_count}, {16'h0, mcount});
                // A slot can take a word when it is empty or being emptied.
                acc = !mfull[in_sel] || out_ready[in_sel];
                check("in_ready", {31'h0, in_ready}, {31'h0, acc});
                acc = acc && in_valid;
                for (int i = 0; i < 8; i++)
                    if (mfull[i] && out_ready[i]) mfull[i] = 1'b0;
                if (acc) begin
                    mbuf[in_sel]  = in_data;
                    mfull[in_sel] = 1'b1;
                    mcount        = mcount + 16'h1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin : stim
        bit held_acc;
        reset     = 1'b1;
        in_data   = 16'hDEAD;
        in_sel    = 3'd4;
        in_valid  = 1'b1;      // must be ignored while reset is high
        out_ready = 8'hFF;
        model_clear();
        #2;
        check("lit_rst_valid", {24'h0, out_valid}, 32'h0);
        check("lit_rst_ready", {31'h0, in_ready}, 32'h1);
        step();
        step();
        step();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 8'h00;

        // First word right after release: 1234 to channel d.
        in_data  = 16'h1234;
        in_sel   = 3'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("lit_first_valid", {24'h0, out_valid}, 32'h08);
        check("lit_first_d", {16'h0, out_d}, 32'h1234);
        check("lit_first_cnt", {16'h0, word_count}, 32'h1);

        // Fill all eight channels on consecutive cycles.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_data  = 16'(i);
            in_sel   = 3'(i);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("lit_fill_valid", {24'h0, out_valid}, 32'hFF);
        for (int i = 0; i < 8; i++)
            check("lit_fill_out", {16'h0, outs[i]}, 32'(i));
        check("lit_fill_cnt", {16'h0, word_count}, 32'h8);

        // Drain channel c only, no new input.
        out_ready = 8'h04;
        step();
        out_ready = 8'h00;
        check("lit_drain_valid", {24'h0, out_valid}, 32'hFB);
        check("lit_drain_c", {16'h0, out_c}, 32'h2);

        // Back-pressure on full channel f, then release.
        in_data  = 16'hBEEF;
        in_sel   = 3'd5;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("lit_bp_ready", {31'h0, in_ready}, 32'h0);
            step();
            check("lit_bp_f", {16'h0, out_f}, 32'h5);
            check("lit_bp_cnt", {16'h0, word_count}, 32'h8);
        end
        out_ready = 8'h20;
        #1;
        check("lit_rel_ready", {31'h0, in_ready}, 32'h1);
        step();
        in_valid  = 1'b0;
        out_ready = 8'h00;
        check("lit_rel_f", {16'h0, out_f}, 32'hBEEF);
        check("lit_rel_valid5", {31'h0, out_valid[5]}, 32'h1);
        check("lit_rel_cnt", {16'h0, word_count}, 32'h9);

        // Multi-drain with a refill of channel a in the same cycle.
        out_ready = 8'hFF;
        in_data   = 16'hA5A5;
        in_sel    = 3'd0;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 8'h00;
        check("lit_multi_valid", {24'h0, out_valid}, 32'h01);
        check("lit_multi_a", {16'h0, out_a}, 32'hA5A5);
        check("lit_multi_h", {16'h0, out_h}, 32'h7);

        // Mixed traffic; producer holds a word until it is taken.
        held_acc = 1'b1;
        for (int n = 0; n < 400; n++) begin
            out_ready = 8'($urandom);
            if (!in_valid || held_acc) begin
                in_valid = 1'($urandom_range(0, 1));
                in_sel   = 3'($urandom_range(0, 7));
                in_data  = 16'($urandom);
            end
            #1;
            held_acc = in_valid && in_ready;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 8'h00;

        // Counter wrap: 65536 accepts return it to zero.
        do_reset();
        out_ready = 8'h01;
        in_sel    = 3'd0;
        in_valid  = 1'b1;
        for (int n = 0; n < 65536; n++) begin
            in_data = 16'(n);
            step();
        end
        in_valid = 1'b0;
        check("lit_wrap0", {16'h0, word_count}, 32'h0);
        in_valid = 1'b1;
        in_data  = 16'h7777;
        step();
        in_valid  = 1'b0;
        out_ready = 8'h00;
        check("lit_wrap1", {16'h0, word_count}, 32'h1);

        // Asynchronous reset pulse between edges with channels b and g full.
        in_valid = 1'b1;
        in_sel   = 3'd1;
        in_data  = 16'h1111;
        step();
        in_sel   = 3'd6;
        in_data  = 16'h6666;
        step();
        in_valid = 1'b0;
        check("lit_pre_valid", {24'h0, out_valid}, 32'h43);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("lit_async_valid", {24'h0, out_valid}, 32'h0);
        check("lit_async_b", {16'h0, out_b}, 32'h0);
        check("lit_async_g", {16'h0, out_g}, 32'h0);
        check("lit_async_cnt", {16'h0, word_count}, 32'h0);
        check("lit_async_ready", {31'h0, in_ready}, 32'h1);
        model_clear();
        #1;
        reset = 1'b0;
        step();
        step();
        check("lit_post_valid", {24'h0, out_valid}, 32'h0);
        check("lit_post_g", {16'h0, out_g}, 32'h0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        nerr++;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1);
    end

endmodule
